rv64_issue_decoder: RTL and testbench
=====================================

Name: rv64_issue_decoder

Overview:
- Sequential RV64IM decoder that sits between instruction fetch and the execute stage.
- Accepts raw 32-bit instruction words with their PC over a valid/ready handshake.
- Decodes each word into the operation bundle the execute stage consumes: op, rd, rs1, rs2, imm, pc.
- Delivers bundles downstream over a second valid/ready handshake, with a 2-entry skid buffer so neither side sees combinational ready paths.

Parameters:
- XLEN, 64, PC and datapath width.
- IMM_W, 32, width of the sign-extended immediate output.
- CNT_W, 32, width of the decoded/illegal counters.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  drop all buffered instructions
- in_valid  input  1  fetch word valid
- in_ready  output  1  decoder can accept a word
- in_insn  input  32  raw instruction word
- in_pc  input  XLEN  PC of in_insn
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts the bundle
- out_op  output  6  op_e code from the package
- out_rd  output  6  destination register, zero-extended
- out_rs1  output  6  source 1, zero-extended
- out_rs2  output  6  source 2, zero-extended
- out_imm  output  IMM_W  sign-extended immediate
- out_pc  output  XLEN  PC of the bundle
- out_illegal  output  1  bundle is an undecodable word
- decoded_cnt  output  CNT_W  bundles accepted downstream
- illegal_cnt  output  CNT_W  illegal bundles accepted downstream

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=1.
  - Skid buffer empty, both counters 0.
  - All out_* data fields 0, out_op=OP_NONE.
- Latency and ordering:
  - A word accepted (in_valid & in_ready) appears on out_* exactly 1 cycle later when the buffer was empty.
  - Order is strictly preserved.
- Skid buffer:
  - Two entries: head (drives out_*) and skid.
  - in_ready is registered: in_ready = !skid_full.
  - Accept with head busy and !out_ready: the bundle goes to skid.
  - Pop with skid full: skid moves to head in the same cycle.
  - Simultaneous push and pop with head full: the new bundle goes to the head slot if skid is empty, otherwise to skid.
  - out_* is held stable while out_valid & !out_ready.
- Decode (combinational on in_insn, registered into the buffer):
  - Fields: opcode [6:0], rd [11:7], f3 [14:12], rs1 [19:15], rs2 [24:20], f7 [31:25].
  - Supported ops:
    - R-type: add sub sll slt sltu xor srl sra or and.
    - W-type: addw subw sllw srlw sraw.
    - M-extension: mul mulh mulhsu mulhu div divu rem remu, plus mulw divw divuw remw remuw.
    - I-type: addi slti sltiu xori ori andi.
    - Shifts: slli srli srai (6-bit shamt), slliw srliw sraiw (5-bit shamt).
    - Word and upper: addiw, lui, auipc.
    - Jumps: jal, jalr.
  - Immediates:
    - I-type: imm[11:0], sign-extended.
    - Shifts: shamt, zero-extended.
    - U-type: insn[31:12], placed in the low 20 bits and sign-extended (the execute stage does the shift).
    - J-type: {insn[31],insn[19:12],insn[20],insn[30:21],1'b0}, sign-extended.
  - Unused register fields are driven as 0; out_imm is 0 for R-type.
  - Illegal words produce out_op=OP_ILLEGAL, out_illegal=1, rd/rs1/rs2/imm=0, pc passed through. Illegal cases:
    - Unknown opcode.
    - Bad f3/f7 combination.
    - *iw shifts with insn[25]=1.
    - Word 0x00000000.
  - Illegal bundles still flow through the handshake.
- Counters:
  - decoded_cnt increments on each out_valid & out_ready.
  - illegal_cnt additionally increments when out_illegal is set.
  - Both wrap modulo 2^CNT_W.
- flush:
  - Sampled at the clock edge, it empties both entries and sets out_valid=0, in_ready=1.
  - A word presented in the flush cycle is discarded.
  - Counters are not affected.
  - Reset has priority over flush.

Decomposition:
- Package rv64_dec_pkg holds:
  - op_e, a 6-bit enum: OP_NONE, OP_ILLEGAL and one code per supported op.
  - Opcode constants (OPC_OP, OPC_OP_32, OPC_OP_IMM, OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR).
  - Packed struct dec_bundle_t {op, rd, rs1, rs2, imm, pc, illegal}.
- Sub-module rv64_dec_comb: purely combinational, in_insn/in_pc to dec_bundle_t.
- The top level holds only the skid buffer, handshake, flush and counters.

Test Plan:
- addi x1,x0,5: in_insn=0x00500093, pc=0x1000, out_ready=1 -> next cycle OP_ADDI, rd=1, rs1=0, imm=5, pc=0x1000, decoded_cnt=1.
- add 0x002081B3, sub 0x402081B3, mul 0x022081B3 back-to-back -> OP_ADD, OP_SUB, OP_MUL in order on consecutive cycles, each with rd=3, rs1=1, rs2=2.
- jal x1,-4 (0xFFDFF0EF) and srai x1,x1,63 (0x43F0D093) -> imm=0xFFFFFFFC; then OP_SRAI with imm=63.
- Stream 3 words with out_ready=0 -> in_ready falls after 2 accepts, out_* held stable; release out_ready -> all 3 emerge in order with no loss or duplication.
- in_insn=0x00000000 -> OP_ILLEGAL, out_illegal=1, illegal_cnt=1, decoded_cnt=1.
- Skid full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; repeat with rst_n=0 mid-stream -> all outputs and counters at reset values.

Source files
------------

// File: rtl/rv64_dec_pkg.sv
// Shared types for the RV64IM issue decoder: op codes, major opcodes and the
// decoded bundle handed to the execute stage.
package rv64_dec_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned IMM_W = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned REG_W = 6;
    localparam int unsigned OP_W  = 6;

    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_JALR      = 7'h67;

    typedef enum logic [OP_W-1:0] {
        OP_NONE, OP_ILLEGAL,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDIW, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } dec_bundle_t;

endpackage

// File: rtl/rv64_dec_comb.sv
// Combinational RV64IM decode of one instruction word into a dec_bundle_t.
module rv64_dec_comb
    import rv64_dec_pkg::*;
(
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    output dec_bundle_t     bundle
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [IMM_W-1:0] imm_i, imm_sh, imm_shw, imm_u, imm_j;

    assign opcode  = insn[6:0];
    assign f3      = insn[14:12];
    assign f7      = insn[31:25];
    assign imm_i   = IMM_W'($signed(insn[31:20]));
    assign imm_sh  = IMM_W'(insn[25:20]);
    assign imm_shw = IMM_W'(insn[24:20]);
    assign imm_u   = IMM_W'($signed(insn[31:12]));
    assign imm_j   = IMM_W'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));

    op_e              op;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0] imm;

    always_comb begin
        op  = OP_ILLEGAL;
        rd  = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        case (opcode)
            OPC_OP: begin
                rd  = REG_W'(insn[11:7]);
                rs1 = REG_W'(insn[19:15]);
                rs2 = REG_W'(insn[24:20]);
                case (f7)
                    7'h00: case (f3)
                        3'd0: op = OP_ADD;
                        3'd1: op = OP_SLL;
                        3'd2: op = OP_SLT;
                        3'd3: op = OP_SLTU;
                        3'd4: op = OP_XOR;
                        3'd5: op = OP_SRL;
                        3'd6: op = OP_OR;
                        3'd7: op = OP_AND;
                    endcase
                    7'h20: begin
                        if (f3 == 3'd0)      op = OP_SUB;
                        else if (f3 == 3'd5) op = OP_SRA;
                    end
                    7'h01: case (f3)
                        3'd0: op = OP_MUL;
                        3'd1: op = OP_MULH;
                        3'd2: op = OP_MULHSU;
                        3'd3: op = OP_MULHU;
                        3'd4: op = OP_DIV;
                        3'd5: op = OP_DIVU;
                        3'd6: op = OP_REM;
                        3'd7: op = OP_REMU;
                    endcase
                    default: ;
                endcase
            end
            OPC_OP_32: begin
                rd  = REG_W'(insn[11:7]);
                rs1 = REG_W'(insn[19:15]);
                rs2 = REG_W'(insn[24:20]);
                case (f7)
                    7'h00: begin
                        if (f3 == 3'd0)      op = OP_ADDW;
                        else if (f3 == 3'd1) op = OP_SLLW;
                        else if (f3 == 3'd5) op = OP_SRLW;
                    end
                    7'h20: begin
                        if (f3 == 3'd0)      op = OP_SUBW;
                        else if (f3 == 3'd5) op = OP_SRAW;
                    end
                    7'h01: case (f3)
                        3'd0:    op = OP_MULW;
                        3'd4:    op = OP_DIVW;
                        3'd5:    op = OP_DIVUW;
                        3'd6:    op = OP_REMW;
                        3'd7:    op = OP_REMUW;
                        default: ;
                    endcase
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                rd  = REG_W'(insn[11:7]);
                rs1 = REG_W'(insn[19:15]);
                imm = imm_i;
                case (f3)
                    3'd0: op = OP_ADDI;
                    3'd2: op = OP_SLTI;
                    3'd3: op = OP_SLTIU;
                    3'd4: op = OP_XORI;
                    3'd6: op = OP_ORI;
                    3'd7: op = OP_ANDI;
                    3'd1: begin
                        imm = imm_sh;
                        if (insn[31:26] == 6'b000000) op = OP_SLLI;
                    end
                    3'd5: begin
                        imm = imm_sh;
                        if (insn[31:26] == 6'b000000)      op = OP_SRLI;
                        else if (insn[31:26] == 6'b010000) op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP_IMM_32: begin
                rd  = REG_W'(insn[11:7]);
                rs1 = REG_W'(insn[19:15]);
                // f7 covers insn[25], so a 6-bit shamt on a word shift is rejected here
                if (f3 == 3'd0) begin
                    op  = OP_ADDIW;
                    imm = imm_i;
                end else if (f3 == 3'd1 && f7 == 7'h00) begin
                    op  = OP_SLLIW;
                    imm = imm_shw;
                end else if (f3 == 3'd5 && f7 == 7'h00) begin
                    op  = OP_SRLIW;
                    imm = imm_shw;
                end else if (f3 == 3'd5 && f7 == 7'h20) begin
                    op  = OP_SRAIW;
                    imm = imm_shw;
                end
            end
            OPC_LUI: begin
                op  = OP_LUI;
                rd  = REG_W'(insn[11:7]);
                imm = imm_u;
            end
            OPC_AUIPC: begin
                op  = OP_AUIPC;
                rd  = REG_W'(insn[11:7]);
                imm = imm_u;
            end
            OPC_JAL: begin
                op  = OP_JAL;
                rd  = REG_W'(insn[11:7]);
                imm = imm_j;
            end
            OPC_JALR: begin
                if (f3 == 3'd0) begin
                    op  = OP_JALR;
                    rd  = REG_W'(insn[11:7]);
                    rs1 = REG_W'(insn[19:15]);
                    imm = imm_i;
                end
            end
            default: ;
        endcase

        if (op == OP_ILLEGAL) begin
            rd  = '0;
            rs1 = '0;
            rs2 = '0;
            imm = '0;
        end
    end

    always_comb begin
        bundle         = '0;
        bundle.op      = op;
        bundle.rd      = rd;
        bundle.rs1     = rs1;
        bundle.rs2     = rs2;
        bundle.imm     = imm;
        bundle.pc      = pc;
        bundle.illegal = (op == OP_ILLEGAL);
    end

endmodule

// File: rtl/rv64_issue_decoder.sv
// RV64IM issue decoder: decodes fetch words and hands bundles to execute
// through a 2-entry skid buffer with registered ready/valid on both sides.
module rv64_issue_decoder
    import rv64_dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_insn,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [IMM_W-1:0]  out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  decoded_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HEAD, ST_FULL} state_e;

    state_e            state_q, state_d;
    dec_bundle_t       head_q, head_d, skid_q, skid_d, dec;
    logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
    logic              push, pop;

    rv64_dec_comb u_dec (
        .insn   (in_insn),
        .pc     (in_pc),
        .bundle (dec)
    );

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Buffer occupancy, data movement and counters
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        dec_cnt_d   = dec_cnt_q;
        ill_cnt_d   = ill_cnt_q;

        if (pop) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
            if (head_q.illegal) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = dec;
                        state_d = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (push && pop) begin
                        head_d = dec;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end else if (push) begin
                        skid_d  = dec;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d = skid_q;
                        if (push) skid_d = dec;
                        else      state_d = ST_HEAD;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dec_cnt_q   <= '0;
            ill_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            dec_cnt_q   <= dec_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_op      = head_q.op;
    assign out_rd      = head_q.rd;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_imm     = head_q.imm;
    assign out_pc      = head_q.pc;
    assign out_illegal = head_q.illegal;
    assign decoded_cnt = dec_cnt_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_rv64_issue_decoder.sv
// Scoreboard bench for rv64_issue_decoder: driver queues hand-decoded bundles
// on acceptance, a negedge monitor compares whatever the DUT presents.
module tb_rv64_issue_decoder;
    import rv64_dec_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0]       in_insn;
    logic [XLEN-1:0]   in_pc, out_pc;
    logic [OP_W-1:0]   out_op;
    logic [REG_W-1:0]  out_rd, out_rs1, out_rs2;
    logic [IMM_W-1:0]  out_imm;
    logic [CNT_W-1:0]  decoded_cnt, illegal_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    dec_bundle_t sb[$];

    rv64_issue_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal),
        .decoded_cnt (decoded_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic dec_bundle_t mk(op_e op, int rd, int rs1, int rs2, logic [31:0] imm);
        dec_bundle_t b;
        b         = '0;
        b.op      = op;
        b.rd      = REG_W'(rd);
        b.rs1     = REG_W'(rs1);
        b.rs2     = REG_W'(rs2);
        b.imm     = imm;
        b.illegal = (op == OP_ILLEGAL);
        return b;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the presented bundle with the oldest expected one
    always @(negedge clk) begin
        logic [$bits(dec_bundle_t)-1:0] act;
        dec_bundle_t exp;
        if (rst_n && out_valid) begin
            act = {out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL bundle: unexpected op=%0d pc=0x%0h with nothing pending", out_op, out_pc);
            end else begin
                exp = sb[0];
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL bundle pc=0x%0h: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%0h ill=%b expected op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%0h ill=%b pc=0x%0h",
                             out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm, out_illegal,
                             exp.op, exp.rd, exp.rs1, exp.rs2, exp.imm, exp.illegal, exp.pc);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(logic [31:0] insn, logic [63:0] pc, dec_bundle_t exp);
        bit acc = 1'b0;
        exp.pc   = pc;
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(exp);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: word 0x%08h never accepted, expected acceptance", insn);
        end
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_insn = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_decoded_cnt", 64'(decoded_cnt), 64'd0);
        check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_out_op", 64'(out_op), 64'(OP_NONE));
        check("rst_out_data", {out_imm, out_pc[15:0], out_rd, out_rs1, out_rs2[3:0]}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word, one-cycle latency
        out_ready = 1'b1;
        send(32'h00500093, 64'h1000, mk(OP_ADDI, 1, 0, 0, 32'd5));
        check("latency_out_valid", 64'(out_valid), 64'd1);
        drain();
        check("cnt_after_addi", 64'(decoded_cnt), 64'd1);

        // Back-to-back R-type and M-extension
        send(32'h002081B3, 64'h1004, mk(OP_ADD, 3, 1, 2, 32'd0));
        send(32'h402081B3, 64'h1008, mk(OP_SUB, 3, 1, 2, 32'd0));
        send(32'h022081B3, 64'h100C, mk(OP_MUL, 3, 1, 2, 32'd0));
        send(32'hFFDFF0EF, 64'h2000, mk(OP_JAL, 1, 0, 0, 32'hFFFFFFFC));
        send(32'h43F0D093, 64'h2004, mk(OP_SRAI, 1, 1, 0, 32'd63));
        send(32'h12345117, 64'h2008, mk(OP_AUIPC, 2, 0, 0, 32'h00012345));
        send(32'h00808067, 64'h200C, mk(OP_JALR, 0, 1, 0, 32'd8));
        send(32'h0262F23B, 64'h2010, mk(OP_REMUW, 4, 5, 6, 32'd0));
        send(32'h41F1D19B, 64'h2014, mk(OP_SRAIW, 3, 3, 0, 32'd31));
        drain();
        check("cnt_after_burst", 64'(decoded_cnt), 64'd10);

        // Backpressure: skid fills, third word waits, then all drain in order
        out_ready = 1'b0;
        send(32'hFFF37293, 64'h3000, mk(OP_ANDI, 5, 6, 0, 32'hFFFFFFFF));
        check("stall_ready_after1", 64'(in_ready), 64'd1);
        send(32'h800003B7, 64'h3004, mk(OP_LUI, 7, 0, 0, 32'hFFF80000));
        check("stall_ready_after2", 64'(in_ready), 64'd0);
        fork
            send(32'h00C5853B, 64'h3008, mk(OP_ADDW, 10, 11, 12, 32'd0));
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_ready_held", 64'(in_ready), 64'd0);
                check("stall_valid_held", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check("cnt_after_stall", 64'(decoded_cnt), 64'd13);

        // Illegal words still flow and count
        send(32'h00000000, 64'h4000, mk(OP_ILLEGAL, 0, 0, 0, 32'd0));
        send(32'h0200909B, 64'h4004, mk(OP_ILLEGAL, 0, 0, 0, 32'd0));
        drain();
        check("illegal_cnt", 64'(illegal_cnt), 64'd2);
        check("cnt_after_illegal", 64'(decoded_cnt), 64'd15);

        // Flush with skid full and a word presented in the flush cycle
        out_ready = 1'b0;
        send(32'h00500093, 64'h5000, mk(OP_ADDI, 1, 0, 0, 32'd5));
        send(32'h002081B3, 64'h5004, mk(OP_ADD, 3, 1, 2, 32'd0));
        in_valid = 1'b1; in_insn = 32'h402081B3; in_pc = 64'h5008;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_cnt_kept", 64'(decoded_cnt), 64'd15);
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("flush_discarded", 64'(out_valid), 64'd0);
        send(32'h022081B3, 64'h6000, mk(OP_MUL, 3, 1, 2, 32'd0));
        check("post_flush_latency", 64'(out_valid), 64'd1);
        drain();
        check("cnt_after_flush", 64'(decoded_cnt), 64'd16);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'hFFF37293, 64'h7000, mk(OP_ANDI, 5, 6, 0, 32'hFFFFFFFF));
        send(32'h800003B7, 64'h7004, mk(OP_LUI, 7, 0, 0, 32'hFFF80000));
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_decoded_cnt", 64'(decoded_cnt), 64'd0);
        check("rst2_illegal_cnt", 64'(illegal_cnt), 64'd0);
        check("rst2_out_op", 64'(out_op), 64'(OP_NONE));
        check("rst2_out_data", {out_imm, out_pc[15:0], out_rd, out_rs1, out_rs2[3:0]}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h00500093, 64'h8000, mk(OP_ADDI, 1, 0, 0, 32'd5));
        drain();
        check("cnt_after_reset", 64'(decoded_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
